// File: rtl/reg_write_buffer_pkg.sv
// Shared widths, constants and the pending-write entry type for the register write buffer.
package reg_write_buffer_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/reg_write_buffer_fwd_match.sv
// Youngest-match lookup of a read address across the valid pending-write entries.
module rwb_fwd_match
  import reg_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  wr_entry_t          entries_i [DEPTH],
  input  logic [DEPTH-1:0]   valid_i,
  input  logic [PW-1:0]      rd_ptr_i,
  input  logic [AW_DEF-1:0]  addr_i,
  output logic               hit_o,
  output logic [DW_DEF-1:0]  data_o
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from rd_ptr so the last match seen is the youngest.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PW'(rd_ptr_i + PW'(i));
      if (valid_i[idx] && (entries_i[idx].addr == addr_i) && (addr_i != REG_ZERO)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_write_buffer.sv
// Queues writeback requests, drains one per cycle to the Register write port and
// forwards pending data to decode's two read ports.
module reg_write_buffer
  import reg_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          drain_en,
  output logic          WriteRegister,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  input  logic [AW-1:0] ReadRegister1,
  input  logic [AW-1:0] ReadRegister2,
  input  logic [DW-1:0] ReadData1,
  input  logic [DW-1:0] ReadData2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  wr_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             we_q,     we_d;
  wr_entry_t        out_q,    out_d;

  logic             push;
  logic             pop;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    off;

  logic             hit1, hit2;
  logic [DW-1:0]    hdata1, hdata2;

  assign wr_ready = (count_q < CW'(DEPTH));
  // Writes to the zero register complete the handshake but are never stored.
  assign push     = wr_valid & wr_ready & (wr_addr != REG_ZERO);
  assign pop      = drain_en & (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    we_d     = pop;
    if (push) begin
      wr_ptr_d = PW'(wr_ptr_q + PW'(1));
    end
    if (pop) begin
      rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      out_d    = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      out_q    <= out_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
    end
  end

  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(PW'(i) - rd_ptr_q);
      valid[i] = (CW'(off) < count_q);
    end
  end

  rwb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd1 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .rd_ptr_i  (rd_ptr_q),
    .addr_i    (ReadRegister1),
    .hit_o     (hit1),
    .data_o    (hdata1)
  );

  rwb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd2 (
    .entries_i (mem_q),
    .valid_i   (valid),
    .rd_ptr_i  (rd_ptr_q),
    .addr_i    (ReadRegister2),
    .hit_o     (hit2),
    .data_o    (hdata2)
  );

  // FIFO entries are younger than the output stage, so a FIFO hit takes priority.
  always_comb begin
    fwd_data1 = ReadData1;
    fwd_data2 = ReadData2;
    if (ReadRegister1 != REG_ZERO) begin
      if (hit1)                                  fwd_data1 = hdata1;
      else if (we_q && out_q.addr == ReadRegister1) fwd_data1 = out_q.data;
    end
    if (ReadRegister2 != REG_ZERO) begin
      if (hit2)                                  fwd_data2 = hdata2;
      else if (we_q && out_q.addr == ReadRegister2) fwd_data2 = out_q.data;
    end
  end

  assign WriteRegister = we_q;
  assign WriteReg      = out_q.addr;
  assign WriteData     = out_q.data;
  assign count         = count_q;
  assign empty         = (count_q == '0) & ~we_q;

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: queue model plus write scoreboard, and a forwarding table.
module tb_reg_write_buffer;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct packed {
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] e1;
    logic [31:0] e2;
  } fwd_vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        drain_en;
  logic        WriteRegister;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  ent_t mq[$];
  ent_t exp_q[$];
  ent_t mout;
  bit   mwe;

  fwd_vec_t tv [5];

  always #5 clock = ~clock;

  reg_write_buffer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .drain_en      (drain_en),
    .WriteRegister (WriteRegister),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .fwd_data1     (fwd_data1),
    .fwd_data2     (fwd_data2),
    .count         (count),
    .empty         (empty)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_fwd(input logic [4:0] ra, input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
    if (ra != 5'd0) begin
      if (mwe && mout.addr == ra) r = mout.data;
      foreach (mq[i]) if (mq[i].addr == ra) r = mq[i].data;
    end
    return r;
  endfunction

  // One clock: update the model from pre-edge inputs, then compare after the edge.
  task automatic tick();
    bit   p, q;
    ent_t e;
    p = !reset && wr_valid && (mq.size() < DEPTH) && (wr_addr != 5'd0);
    q = !reset && drain_en && (mq.size() > 0);
    @(posedge clock);
    if (reset) begin
      mq.delete();
      exp_q.delete();
      mwe  = 1'b0;
      mout = '0;
    end else begin
      if (q) begin
        mout = mq.pop_front();
        exp_q.push_back(mout);
      end
      if (p) mq.push_back({wr_addr, wr_data});
      mwe = q;
    end
    #2;
    chk("count", 64'(count), 64'(mq.size()));
    chk("write_en", 64'(WriteRegister), 64'(mwe));
    chk("empty", 64'(empty), 64'(mq.size() == 0 && !mwe));
    chk("wr_ready", 64'(wr_ready), 64'(mq.size() < DEPTH));
    if (WriteRegister) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_write actual=addr %0h required=no write", WriteReg);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(WriteReg), 64'(e.addr));
        chk("write_data", 64'(WriteData), 64'(e.data));
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    chk("fwd1", 64'(fwd_data1), 64'(exp_fwd(ReadRegister1, ReadData1)));
    chk("fwd2", 64'(fwd_data2), 64'(exp_fwd(ReadRegister2, ReadData2)));
  endtask

  task automatic push_one(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    tv[0] = '{rr1: 5'd21, rr2: 5'd9,  rd1: 32'h11111111, rd2: 32'h22222222, e1: 32'hB2B2B2B2, e2: 32'hC3C3C3C3};
    tv[1] = '{rr1: 5'd9,  rr2: 5'd0,  rd1: 32'h33333333, rd2: 32'h44444444, e1: 32'hC3C3C3C3, e2: 32'h44444444};
    tv[2] = '{rr1: 5'd0,  rr2: 5'd21, rd1: 32'h55555555, rd2: 32'h66666666, e1: 32'h55555555, e2: 32'hB2B2B2B2};
    tv[3] = '{rr1: 5'd3,  rr2: 5'd4,  rd1: 32'h77777777, rd2: 32'h88888888, e1: 32'h77777777, e2: 32'h88888888};
    tv[4] = '{rr1: 5'd21, rr2: 5'd21, rd1: 32'h99999999, rd2: 32'h12345678, e1: 32'hB2B2B2B2, e2: 32'hB2B2B2B2};

    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; drain_en = 1'b0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    ReadData1 = 32'hAAAA0001; ReadData2 = 32'hBBBB0002;
    mq.delete(); exp_q.delete(); mwe = 1'b0; mout = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_waddr", 64'(WriteReg), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);

    // Single write, one-cycle drain latency.
    drain_en = 1'b1;
    push_one(5'd7, 32'h0143C120);
    tick();
    chk("t1_we", 64'(WriteRegister), 64'd1);
    chk("t1_waddr", 64'(WriteReg), 64'd7);
    chk("t1_wdata", 64'(WriteData), 64'h0143C120);
    tick();
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill with drain blocked; fifth request must stall.
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(i + 1);
      wr_data  = $urandom;
      tick();
    end
    wr_valid = 1'b0;
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_ready", 64'(wr_ready), 64'd0);
    drain_en = 1'b1;
    repeat (5) tick();
    chk("t2_drained", 64'(count), 64'd0);

    // Forwarding: youngest same-address entry wins.
    drain_en = 1'b0;
    push_one(5'd21, 32'hA1A1A1A1);
    push_one(5'd21, 32'hB2B2B2B2);
    push_one(5'd9,  32'hC3C3C3C3);
    ReadRegister2 = 5'd21;
    #1;
    chk("t3_fwd2_young", 64'(fwd_data2), 64'hB2B2B2B2);
    for (int i = 0; i < 5; i++) begin
      ReadRegister1 = tv[i].rr1;
      ReadRegister2 = tv[i].rr2;
      ReadData1     = tv[i].rd1;
      ReadData2     = tv[i].rd2;
      #1;
      chk($sformatf("tv%0d_fwd1", i), 64'(fwd_data1), 64'(tv[i].e1));
      chk($sformatf("tv%0d_fwd2", i), 64'(fwd_data2), 64'(tv[i].e2));
    end
    ReadData1 = 32'hAAAA0001; ReadData2 = 32'hBBBB0002;
    ReadRegister1 = 5'd9; ReadRegister2 = 5'd21;
    drain_en = 1'b1;
    repeat (4) tick();
    chk("t3_fwd2_after", 64'(fwd_data2), 64'(ReadData2));

    // Zero-register write: accepted, dropped, never forwarded.
    ReadRegister1 = 5'd0;
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1;
    chk("t4_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    chk("t4_count", 64'(count), 64'd0);
    tick();
    chk("t4_we", 64'(WriteRegister), 64'd0);
    chk("t4_fwd1", 64'(fwd_data1), 64'(ReadData1));

    // Simultaneous push and pop at count 2, pointers wrap over 8 pushes.
    drain_en = 1'b0;
    push_one(5'd10, 32'h10101010);
    push_one(5'd11, 32'h11111111);
    drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 5'(12 + i);
      wr_data  = 32'(32'h5A000000 + i);
      tick();
      chk("t5_count", 64'(count), 64'd2);
    end
    wr_valid = 1'b0;
    repeat (3) tick();

    // Reset with pending entries and a live output stage.
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) push_one(5'(20 + i), 32'(32'hD0000000 + i));
    drain_en = 1'b1;
    tick();
    chk("t6_pre_count", 64'(count), 64'd3);
    chk("t6_pre_we", 64'(WriteRegister), 64'd1);
    ReadRegister1 = 5'd20; ReadRegister2 = 5'd22;
    reset = 1'b1; drain_en = 1'b0;
    tick();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_we", 64'(WriteRegister), 64'd0);
    chk("t6_ready", 64'(wr_ready), 64'd1);
    chk("t6_fwd1", 64'(fwd_data1), 64'(ReadData1));
    chk("t6_fwd2", 64'(fwd_data2), 64'(ReadData2));
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
